// File: rtl/gen_test_trigger_if.sv
// Control and status bundle for gen_test_trigger.
// The master side (the controller) drives the run configuration; the slave side (the generator) drives the trigger and status outputs.
interface gen_test_trigger_if #(
  parameter int CNT_W   = 16,
  parameter int PAT_LEN = 8
);
  logic               ene;
  logic [CNT_W-1:0]   ntrig;
  logic [CNT_W-1:0]   gap;
  logic [PAT_LEN-1:0] pat_pre;
  logic [PAT_LEN-1:0] pat_l1;
  logic               trigger;
  logic               trig_pre;
  logic               trig_l1;
  logic [CNT_W-1:0]   counter;
  logic [CNT_W-1:0]   sent;
  logic               busy;
  logic               done;
  logic               overlap;

  modport master (
    output ene, ntrig, gap, pat_pre, pat_l1,
    input  trigger, trig_pre, trig_l1, counter, sent, busy, done, overlap
  );

  modport slave (
    input  ene, ntrig, gap, pat_pre, pat_l1,
    output trigger, trig_pre, trig_l1, counter, sent, busy, done, overlap
  );
endinterface

// File: rtl/gen_test_trigger.sv
// Test-trigger generator: spaced seeds feed a delay line.
// The delay line's short and long taps launch the patterned pre and L1 serial bursts.
module gen_test_trigger #(
  parameter int CNT_W     = 16,
  parameter int PAT_LEN   = 8,
  parameter int PRE_DELAY = 5,
  parameter int L1_DELAY  = 330
) (
  input logic              clk,
  input logic              rst,
  gen_test_trigger_if.slave bus
);

  localparam int IDX_W = $clog2(PAT_LEN + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_LEN);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} ser_state_e;

  logic [CNT_W-1:0]    counter_q, counter_d;
  logic [CNT_W-1:0]    sent_q, sent_d;
  logic [CNT_W-1:0]    gap_eff_s;
  logic                run_s, seed_s;
  logic [L1_DELAY-1:0] dl_q, dl_d;

  // Serialiser slot 0 is the pre burst; slot 1 is the L1 burst.
  ser_state_e          state_q [2];
  ser_state_e          state_d [2];
  logic [PAT_LEN-1:0]  sh_q [2];
  logic [PAT_LEN-1:0]  sh_d [2];
  logic [IDX_W-1:0]    idx_q [2];
  logic [IDX_W-1:0]    idx_d [2];
  logic                bit_q [2];
  logic                bit_d [2];
  logic                launch_s [2];
  logic                drop_s [2];
  logic [PAT_LEN-1:0]  pat_in_s [2];

  logic trigger_q, trigger_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic overlap_q, overlap_d;

  // Seed generation: sent==0 marks the first enabled cycle of a run.
  always_comb begin
    gap_eff_s = (bus.gap == {CNT_W{1'b0}}) ? CNT_W'(1) : bus.gap;
    run_s     = bus.ene && (sent_q < bus.ntrig);
    seed_s    = run_s && ((sent_q == {CNT_W{1'b0}}) || (counter_q == gap_eff_s));
    counter_d = counter_q;
    sent_d    = sent_q;
    if (seed_s) begin
      counter_d = CNT_W'(1);
      sent_d    = sent_q + CNT_W'(1);
    end else if (run_s && (counter_q != {CNT_W{1'b1}})) begin
      counter_d = counter_q + CNT_W'(1);
    end else begin
      counter_d = counter_q;
    end
    dl_d = {dl_q[L1_DELAY-2:0], seed_s};
  end

  // Both serialisers; a launch that lands on the final bit restarts back-to-back.
  always_comb begin
    launch_s[0] = dl_q[PRE_DELAY-1];
    launch_s[1] = dl_q[L1_DELAY-1];
    pat_in_s[0] = bus.pat_pre;
    pat_in_s[1] = bus.pat_l1;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      sh_d[i]    = sh_q[i];
      idx_d[i]   = idx_q[i];
      bit_d[i]   = 1'b0;
      drop_s[i]  = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (launch_s[i]) begin
            state_d[i] = SEND;
            sh_d[i]    = pat_in_s[i] >> 1;
            bit_d[i]   = pat_in_s[i][0];
            idx_d[i]   = IDX_W'(1);
          end else begin
            state_d[i] = IDLE;
          end
        end
        SEND: begin
          if (idx_q[i] == LAST_IDX) begin
            if (launch_s[i]) begin
              state_d[i] = SEND;
              sh_d[i]    = pat_in_s[i] >> 1;
              bit_d[i]   = pat_in_s[i][0];
              idx_d[i]   = IDX_W'(1);
            end else begin
              state_d[i] = IDLE;
              idx_d[i]   = {IDX_W{1'b0}};
            end
          end else begin
            bit_d[i]  = sh_q[i][0];
            sh_d[i]   = sh_q[i] >> 1;
            idx_d[i]  = idx_q[i] + IDX_W'(1);
            drop_s[i] = launch_s[i];
          end
        end
        default: begin
          state_d[i] = IDLE;
          idx_d[i]   = {IDX_W{1'b0}};
        end
      endcase
    end
  end

  // Status: computed from next-state so it moves on the same edge as the data.
  always_comb begin
    trigger_d = bit_d[0] | bit_d[1];
    busy_d    = (dl_d != {L1_DELAY{1'b0}}) || (state_d[0] == SEND) || (state_d[1] == SEND);
    done_d    = bus.ene && (sent_d == bus.ntrig) && !busy_d;
    overlap_d = overlap_q | drop_s[0] | drop_s[1];
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter_q <= {CNT_W{1'b0}};
      sent_q    <= {CNT_W{1'b0}};
      dl_q      <= {L1_DELAY{1'b0}};
      trigger_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overlap_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        sh_q[i]    <= {PAT_LEN{1'b0}};
        idx_q[i]   <= {IDX_W{1'b0}};
        bit_q[i]   <= 1'b0;
      end
    end else begin
      counter_q <= counter_d;
      sent_q    <= sent_d;
      dl_q      <= dl_d;
      trigger_q <= trigger_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overlap_q <= overlap_d;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        sh_q[i]    <= sh_d[i];
        idx_q[i]   <= idx_d[i];
        bit_q[i]   <= bit_d[i];
      end
    end
  end

  assign bus.trigger  = trigger_q;
  assign bus.trig_pre = bit_q[0];
  assign bus.trig_l1  = bit_q[1];
  assign bus.counter  = counter_q;
  assign bus.sent     = sent_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overlap  = overlap_q;

endmodule

// File: tb/tb_gen_test_trigger.sv
// Directed self-checking bench for gen_test_trigger with default parameters.
module tb_gen_test_trigger;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   now_e;
  int   e0;
  int   hits;
  logic [7:0] obs_pat;

  gen_test_trigger_if #(.CNT_W(16), .PAT_LEN(8)) bus_if ();

  gen_test_trigger #(
    .CNT_W(16), .PAT_LEN(8), .PRE_DELAY(5), .L1_DELAY(330)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      now_e++;
    end
  endtask

  task automatic go(input int e);
    tick(e - now_e);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setup(input logic [15:0] nt, input logic [15:0] gp,
                       input logic [7:0] pp, input logic [7:0] pl);
    bus_if.ene     = 1'b0;
    bus_if.ntrig   = nt;
    bus_if.gap     = gp;
    bus_if.pat_pre = pp;
    bus_if.pat_l1  = pl;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    now_e  = 0;
    hits   = 0;
    obs_pat = 8'h00;

    // Reset state
    setup(16'd3, 16'd400, 8'b0000_0111, 8'b0000_0001);
    check("rst_outputs", {bus_if.trigger, bus_if.trig_pre, bus_if.trig_l1,
                          bus_if.busy, bus_if.done, bus_if.overlap}, 32'd0);
    check("rst_counters", {bus_if.counter, bus_if.sent}, 32'd0);

    // Basic run
    bus_if.ene = 1'b1;
    e0 = now_e + 1;
    go(e0);
    check("basic_first_seed", {bus_if.sent, bus_if.counter}, {16'd1, 16'd1});
    check("basic_busy_rise", bus_if.busy, 32'd1);
    go(e0 + 4);
    check("basic_pre_before", bus_if.trig_pre, 32'd0);
    hits = 0;
    for (int k = 5; k < 13; k++) begin
      go(e0 + k);
      obs_pat[k-5] = bus_if.trig_pre;
      hits += bus_if.trigger;
    end
    check("basic_pre_pattern", obs_pat, 32'h07);
    check("basic_trigger_or_pre", hits, 32'd3);
    go(e0 + 329);
    check("basic_l1_before", bus_if.trig_l1, 32'd0);
    go(e0 + 330);
    check("basic_l1_bit", {bus_if.trig_l1, bus_if.trigger}, 32'b11);
    go(e0 + 331);
    check("basic_l1_after", bus_if.trig_l1, 32'd0);
    go(e0 + 399);
    check("basic_counter_gap", {bus_if.sent, bus_if.counter}, {16'd1, 16'd400});
    go(e0 + 400);
    check("basic_second_seed", {bus_if.sent, bus_if.counter}, {16'd2, 16'd1});
    go(e0 + 805);
    check("basic_third_pre", {bus_if.sent, 15'd0, bus_if.trig_pre}, {16'd3, 16'd1});
    go(e0 + 1137);
    check("basic_not_done", {bus_if.busy, bus_if.done}, 32'b10);
    go(e0 + 1138);
    check("basic_done", {bus_if.busy, bus_if.done, bus_if.overlap}, 32'b010);

    // Gap zero: consecutive seeds, later launches dropped
    setup(16'd4, 16'd0, 8'b0000_0001, 8'b0000_0000);
    check("gap0_rst_overlap", bus_if.overlap, 32'd0);
    bus_if.ene = 1'b1;
    e0 = now_e + 1;
    go(e0 + 3);
    check("gap0_sent", bus_if.sent, 32'd4);
    go(e0 + 4);
    check("gap0_sent_hold", bus_if.sent, 32'd4);
    hits = 0;
    for (int k = 5; k < 20; k++) begin
      go(e0 + k);
      hits += bus_if.trig_pre;
    end
    check("gap0_single_pulse", hits, 32'd1);
    check("gap0_overlap", bus_if.overlap, 32'd1);

    // Back-to-back boundary
    setup(16'd2, 16'd8, 8'hFF, 8'h00);
    bus_if.ene = 1'b1;
    e0 = now_e + 1;
    go(e0 + 4);
    check("b2b_pre_before", bus_if.trig_pre, 32'd0);
    hits = 0;
    for (int k = 5; k < 21; k++) begin
      go(e0 + k);
      hits += bus_if.trig_pre;
    end
    check("b2b_16_high", hits, 32'd16);
    go(e0 + 21);
    check("b2b_pre_after", {bus_if.trig_pre, bus_if.overlap}, 32'd0);
    go(e0 + 346);
    check("b2b_done_no_overlap", {bus_if.done, bus_if.overlap}, 32'b10);

    // Enable pause
    setup(16'd5, 16'd10, 8'b0000_0111, 8'b0000_0001);
    bus_if.ene = 1'b1;
    e0 = now_e + 1;
    go(e0 + 10);
    check("pause_second_seed", {bus_if.sent, bus_if.counter}, {16'd2, 16'd1});
    bus_if.ene = 1'b0;
    go(e0 + 15);
    check("pause_inflight_pre", bus_if.trig_pre, 32'd1);
    go(e0 + 60);
    check("pause_hold", {bus_if.sent, bus_if.counter}, {16'd2, 16'd1});
    bus_if.ene = 1'b1;
    go(e0 + 69);
    check("pause_resume_count", {bus_if.sent, bus_if.counter}, {16'd2, 16'd10});
    go(e0 + 70);
    check("pause_third_seed", {bus_if.sent, bus_if.counter}, {16'd3, 16'd1});
    go(e0 + 75);
    check("pause_third_pre", bus_if.trig_pre, 32'd1);
    go(e0 + 340);
    check("pause_second_l1", bus_if.trig_l1, 32'd1);

    // Reset mid L1 burst
    setup(16'd3, 16'd20, 8'hFF, 8'hFF);
    bus_if.ene = 1'b1;
    e0 = now_e + 1;
    go(e0 + 332);
    check("mrst_l1_active", bus_if.trig_l1, 32'd1);
    rst = 1'b1;
    bus_if.ene = 1'b0;
    go(e0 + 333);
    check("mrst_outputs_zero", {bus_if.trigger, bus_if.trig_pre, bus_if.trig_l1,
                                bus_if.busy, bus_if.done, bus_if.overlap}, 32'd0);
    check("mrst_counters_zero", {bus_if.counter, bus_if.sent}, 32'd0);
    rst = 1'b0;
    hits = 0;
    for (int k = 334; k < 420; k++) begin
      go(e0 + k);
      hits += bus_if.trigger + bus_if.busy;
    end
    check("mrst_no_late_bursts", hits, 32'd0);

    // Pattern latched at launch
    setup(16'd1, 16'd100, 8'hA5, 8'h00);
    bus_if.ene = 1'b1;
    e0 = now_e + 1;
    for (int k = 5; k < 13; k++) begin
      go(e0 + k);
      obs_pat[k-5] = bus_if.trig_pre;
      bus_if.pat_pre = 8'h5A;
    end
    check("latch_pattern", obs_pat, 32'hA5);

    // Zero seed count
    setup(16'd0, 16'd5, 8'hFF, 8'hFF);
    check("zero_done_low", bus_if.done, 32'd0);
    bus_if.ene = 1'b1;
    tick(1);
    check("zero_done", {bus_if.done, bus_if.busy}, 32'b10);
    hits = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      hits += bus_if.trigger;
    end
    check("zero_no_trigger", {bus_if.sent, 16'(hits)}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gen_test_trigger.md
# gen_test_trigger

Parametrised test-trigger generator for the trigger distribution path. It emits a programmable number of seed events at a programmable spacing. Each seed is carried through a fixed delay line and produces two independently patterned serial bursts: a pre-trigger burst at a short tap and an L1 burst at a long tap. Both bursts are merged onto the `trigger` line. It feeds the same downstream trigger serialisers as the existing pre-trigger generator and adds programmable burst patterns, a working L1 burst, overlap detection, and run-completion status.

## Interface
- `CNT_W`, 16: width of `ntrig`, `gap`, `counter`, `sent`.
- `PAT_LEN`, 8: burst length in cycles, ≥2.
- `PRE_DELAY`, 5: seed-to-pre-burst delay in cycles, ≥1.
- `L1_DELAY`, 330: seed-to-L1-burst delay in cycles, > `PRE_DELAY`.

- `clk`  in  1  Single clock. Synchronous, active-high reset.
- `rst`  in  1  Synchronous active-high reset.
- `ene`  in  1  Level enable for seed generation.
- `ntrig`  in  CNT_W  Number of seeds per run.
- `gap`  in  CNT_W  Seed period in cycles. 0 is treated as 1.
- `pat_pre`  in  PAT_LEN  Pre-burst pattern, bit 0 sent first.
- `pat_l1`  in  PAT_LEN  L1-burst pattern, bit 0 sent first.
- `trigger`  out  1  `trig_pre | trig_l1`, registered.
- `trig_pre`  out  1  Pre-burst serial bit.
- `trig_l1`  out  1  L1-burst serial bit.
- `counter`  out  CNT_W  Cycles since the last seed.
- `sent`  out  CNT_W  Seeds issued this run.
- `busy`  out  1  Delay line non-empty or either serialiser active.
- `done`  out  1  `ene && sent==ntrig && !busy`.
- `overlap`  out  1  Sticky flag: a burst launch was dropped.

## Operation
- **Seed generator.** While `ene` is high and `sent < ntrig`, `counter` increments each cycle.
  - A seed fires on the first enabled cycle of a run, and thereafter whenever `counter == max(gap,1)`.
  - On a seed: `counter` is set to 1 and `sent` increments.
  - `ene` low holds `counter` and `sent`. The delay line and serialisers keep running.
- **Delay line.** An `L1_DELAY`-deep shift register takes a 1 at position 0 on a seed cycle, else 0, and shifts every cycle.
  - Tap `PRE_DELAY` launches the pre serialiser.
  - Tap `L1_DELAY` launches the L1 serialiser.
- **Serialiser.** Each of the two has states IDLE and SEND.
  - IDLE→SEND on launch. The pattern input is latched at launch and the bit index is cleared.
  - In SEND, one bit is output per cycle, bit index 0 to `PAT_LEN-1`, then back to IDLE.
  - The output bit is 0 in IDLE.
  - Pattern inputs may change freely. Only the latched copy is used.
- **Overlap.** A launch arriving while a serialiser is in SEND is dropped and sets `overlap`.
  - Exception: a launch in the same cycle as the final bit is accepted. The serialiser restarts back-to-back with no idle cycle.
  - `overlap` clears only on `rst`.
  - No overlap occurs if `gap ≥ PAT_LEN`.
- **Arithmetic.** All counters are unsigned `CNT_W` bits.
  - `counter` saturates at all-ones rather than wrapping.
  - `ntrig == 0`: no seeds are issued, and `done` is asserted as soon as `ene` is high.
  - Lowering `ntrig` below `sent` mid-run stops seeding. `sent` is not changed.
- **Runs.** A new run requires `rst`. `sent` only clears on reset.

## Timing
- **Reset values.** `trigger`, `trig_pre`, `trig_l1`, `counter`, `sent`, `busy`, `done`, `overlap` are all 0. The delay line and serialisers are cleared to IDLE.
  - Reset mid-burst truncates the burst immediately. The next-cycle output is 0.
- **Seed latency.** Let E0 be the clock edge that registers a seed.
  - `trig_pre` carries `pat_pre[k]` from edge E0+PRE_DELAY+k, for k = 0…PAT_LEN-1.
  - `trig_l1` carries `pat_l1[k]` from edge E0+L1_DELAY+k.
  - `trigger` is registered at the same edge as its components. It is their OR, with no extra latency.
- **Status timing.** `sent` and `counter` update at E0.
  - `busy` rises at E0.
  - `busy` falls at the edge after the last L1 bit of the last in-flight seed.
  - `done` rises together with the fall of `busy`.
- **Burst overlap.** Pre and L1 bursts of different seeds may overlap in time. `trigger` ORs them, and this is not an error.

## Test plan
- **Basic run.** `rst`, then `ene=1`, `ntrig=3`, `gap=400`, `pat_pre=8'b0000_0111`, `pat_l1=8'b0000_0001` → three seeds 400 cycles apart.
  - Each seed produces `trig_pre` high for 3 cycles starting E0+5, and `trig_l1` high for 1 cycle at E0+330.
  - `sent=3`, then `done=1` at E0(last)+338.
- **Gap zero.** `gap=0`, `ntrig=4`, `pat_pre=8'b1` → seeds on 4 consecutive cycles.
  - `trig_pre` pulses once at E0+5 only.
  - The other three launches are dropped, and `overlap=1`.
- **Back-to-back boundary.** `gap=8`, `pat_pre=8'hFF`, `ntrig=2` → `trig_pre` high for 16 consecutive cycles and `overlap=0`.
- **Enable pause.** `gap=10`, `ntrig=5`, `ene` dropped for 50 cycles after 2 seeds → `counter` and `sent=2` hold during the pause.
  - In-flight bursts still complete.
  - Seeding resumes with correct spacing once `ene` returns high.
- **Reset mid-operation.** Assert `rst` 3 cycles into an L1 burst → all outputs are 0 on the next edge.
  - No later bursts appear from seeds that were in flight.
- **Pattern latching and zero count.** Change `pat_pre` mid-burst → the burst bits follow the value latched at launch.
  - `ntrig=0` with `ene=1` → no triggers and `done=1` after one cycle.
